// File: rtl/lcd_dbi_bus_writer.sv
// Pixel FIFO feeding an 8080/DBI parallel LCD write bus: window header, then IMG_W*IMG_H pixels.
// Define LCD_BUS8_EN for an 8-bit panel bus (each pixel sent as high byte, then low byte).
module lcd_dbi_bus_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 1,
    parameter int WR_HIGH_CYC = 1,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic [15:0] lcd_db,
    output logic        busy,
    output logic        overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [16:0]   TOTAL     = 17'(IMG_W * IMG_H);
    localparam logic [15:0]   W_M1      = 16'(IMG_W - 1);
    localparam logic [15:0]   H_M1      = 16'(IMG_H - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_DONE} state_t;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr, r_count, w_count_nxt;
    logic          r_ready, r_ovf;
    logic          w_wr, w_pop, w_flush;
    logic [15:0]   w_rd_data;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [16:0]   r_pix_cnt;
    logic [15:0]   r_hold;
    logic          r_hold_vld;
`ifdef LCD_BUS8_EN
    logic          r_byte;
`endif
    logic          r_bus_act, r_ph_hi;
    logic [CW-1:0] r_ph_cnt;
    logic          r_wr_n, r_cs_n, r_rs, r_busy;
    logic [15:0]   r_db;

    logic          w_word_done, w_bus_free, w_start_hdr, w_start_pix, w_hdr_rs, w_pix_last;
    logic [15:0]   w_hdr_word, w_pix_word;

    assign w_rd_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr        = pix_valid & r_ready;
    assign w_flush     = frame_start & (r_state != S_IDLE);
    assign w_word_done = r_bus_act & r_ph_hi & (r_ph_cnt == HIGH_LAST);
    assign w_bus_free  = ~r_bus_act | w_word_done;
    assign w_start_hdr = (r_state == S_HDR) & ~frame_start & w_bus_free;
    assign w_start_pix = (r_state == S_PIX) & ~frame_start & w_bus_free & r_hold_vld;
    // One-pixel prefetch register between FIFO and bus; stop prefetching once the frame's pixels are all issued.
    assign w_pop       = (r_state == S_PIX) & ~frame_start & ~r_hold_vld & (r_count != '0) & (r_pix_cnt != TOTAL);

    always_comb begin
        w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
        if (w_flush) w_count_nxt = (AW+1)'(w_wr);
    end

    always_comb begin
        w_hdr_rs   = 1'b1;
        w_hdr_word = 16'h0000;
        case (r_idx)
            4'd0:    begin w_hdr_rs = 1'b0; w_hdr_word = 16'h002A; end
            4'd3:    w_hdr_word = {8'h00, W_M1[15:8]};
            4'd4:    w_hdr_word = {8'h00, W_M1[7:0]};
            4'd5:    begin w_hdr_rs = 1'b0; w_hdr_word = 16'h002B; end
            4'd8:    w_hdr_word = {8'h00, H_M1[15:8]};
            4'd9:    w_hdr_word = {8'h00, H_M1[7:0]};
            4'd10:   begin w_hdr_rs = 1'b0; w_hdr_word = 16'h002C; end
            default: ;
        endcase
    end

`ifdef LCD_BUS8_EN
    assign w_pix_word = {8'h00, r_byte ? r_hold[7:0] : r_hold[15:8]};
    assign w_pix_last = r_byte;
`else
    assign w_pix_word = r_hold;
    assign w_pix_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            // Flush keeps a pixel written in the same cycle: read pointer jumps to the pre-write position.
            if (w_flush)    r_rd_ptr <= r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != (AW+1)'(FIFO_DEPTH));
            if (pix_valid & ~r_ready) r_ovf <= 1'b1;
            else if (frame_start)     r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_pix_cnt  <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
`ifdef LCD_BUS8_EN
            r_byte     <= 1'b0;
`endif
            r_bus_act  <= 1'b0;
            r_ph_hi    <= 1'b0;
            r_ph_cnt   <= '0;
            r_wr_n     <= 1'b1;
            r_cs_n     <= 1'b1;
            r_rs       <= 1'b1;
            r_db       <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (r_bus_act) begin
                if (!r_ph_hi) begin
                    if (r_ph_cnt == LOW_LAST) begin
                        r_wr_n   <= 1'b1;
                        r_ph_hi  <= 1'b1;
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + CW'(1);
                    end
                end else if (w_word_done) begin
                    r_bus_act <= 1'b0;
                end else begin
                    r_ph_cnt <= r_ph_cnt + CW'(1);
                end
            end
            if (w_start_hdr | w_start_pix) begin
                r_bus_act <= 1'b1;
                r_ph_hi   <= 1'b0;
                r_ph_cnt  <= '0;
                r_wr_n    <= 1'b0;
                r_db      <= w_start_hdr ? w_hdr_word : w_pix_word;
                r_rs      <= w_start_hdr ? w_hdr_rs : 1'b1;
            end
            if (w_pop) begin
                r_hold     <= w_rd_data;
                r_hold_vld <= 1'b1;
            end
            if (w_start_pix) begin
`ifdef LCD_BUS8_EN
                r_byte <= ~r_byte;
`endif
                if (w_pix_last) begin
                    r_hold_vld <= 1'b0;
                    r_pix_cnt  <= r_pix_cnt + 17'd1;
                end
            end
            case (r_state)
                S_IDLE: if (frame_start) begin
                    r_state <= S_HDR;
                    r_idx   <= '0;
                    r_cs_n  <= 1'b0;
                    r_busy  <= 1'b1;
                end
                S_HDR: if (w_start_hdr) begin
                    if (r_idx == 4'd10) begin
                        r_state   <= S_PIX;
                        r_pix_cnt <= '0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_PIX: if (w_word_done && r_pix_cnt == TOTAL) r_state <= S_DONE;
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Restart overrides everything above, including DONE raising cs_n.
            if (w_flush) begin
                r_state    <= S_HDR;
                r_idx      <= '0;
                r_cs_n     <= 1'b0;
                r_busy     <= 1'b1;
                r_hold_vld <= 1'b0;
`ifdef LCD_BUS8_EN
                r_byte     <= 1'b0;
`endif
            end
        end
    end

    assign pix_ready = r_ready;
    assign overflow  = r_ovf;
    assign lcd_cs_n  = r_cs_n;
    assign lcd_rs    = r_rs;
    assign lcd_wr_n  = r_wr_n;
    assign lcd_db    = r_db;
    assign busy      = r_busy;
endmodule
